// File: rtl/uart_rx_cfg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_cfg
//  Purpose  : Parametrised UART receiver. Oversamples the serial line using
//             an external baud_tick, majority-votes three samples per bit and
//             reports each frame with parity, framing and break status.
//  Ports    : clk        - system clock
//             rst        - asynchronous active-high reset
//             rx         - serial line, idle high, asynchronous to clk
//             baud_tick  - one-clk pulse at OVERSAMPLE x baud rate
//             data_out   - last received word, LSB = first bit on the line
//             rx_valid   - one-cycle pulse when a frame completes
//             parity_err - parity mismatch on last frame
//             frame_err  - a stop bit sampled low on last frame
//             break_det  - last frame was a break condition
//             busy       - high in every state except IDLE
//  Revision : 1.0 - initial release
// ============================================================================
module uart_rx_cfg #(
  parameter int DATA_BITS  = 8,   // 5..9
  parameter int PARITY     = 0,   // 0 none, 1 odd, 2 even
  parameter int STOP_BITS  = 1,   // 1 or 2
  parameter int OVERSAMPLE = 16   // power of two, >= 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic                 baud_tick,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 rx_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 break_det,
  output logic                 busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);

  localparam logic [TW-1:0] C_T_S0   = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] C_T_S1   = TW'(OVERSAMPLE / 2);
  localparam logic [TW-1:0] C_T_VOTE = TW'(OVERSAMPLE / 2 + 1);
  localparam logic [TW-1:0] C_T_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] C_B_LAST_DATA = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] C_B_LAST_STOP = BW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_PARITY    = 3'd3,
    S_STOP      = 3'd4,
    S_WAIT_HIGH = 3'd5
  } state_t;

  state_t                 r_state;
  logic                   r_sync1;
  logic                   r_rxs;
  logic [TW-1:0]          r_tcnt;
  logic [BW-1:0]          r_bcnt;
  logic                   r_s0;
  logic                   r_s1;
  logic [DATA_BITS-1:0]   r_shift;
  logic                   r_par_err;
  logic                   r_frm_err;
  logic                   r_par_bit;
  logic                   r_stop0;

  logic w_vote;
  logic w_at_vote;
  logic w_bit_end;
  logic w_xor;
  logic w_par_mis;
  logic w_frm_now;
  logic w_first_stop;
  logic w_brk;

  // The third sample is the live synchronised value on the voting tick.
  assign w_vote    = (r_s0 & r_s1) | (r_s0 & r_rxs) | (r_s1 & r_rxs);
  assign w_at_vote = baud_tick && (r_tcnt == C_T_VOTE);
  assign w_bit_end = baud_tick && (r_tcnt == C_T_LAST);

  // Even parity expects XOR(data, bit) = 0, odd expects 1.
  assign w_xor     = (^r_shift) ^ w_vote;
  assign w_par_mis = (PARITY == 2) ? w_xor : ~w_xor;

  // Status of the frame as it stands at the vote of the last stop bit.
  assign w_frm_now    = r_frm_err | ~w_vote;
  assign w_first_stop = (r_bcnt == '0) ? w_vote : r_stop0;
  assign w_brk        = (r_shift == '0) && ((PARITY == 0) || !r_par_bit) && !w_first_stop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_sync1    <= 1'b1;
      r_rxs      <= 1'b1;
      r_tcnt     <= '0;
      r_bcnt     <= '0;
      r_s0       <= 1'b1;
      r_s1       <= 1'b1;
      r_shift    <= '0;
      r_par_err  <= 1'b0;
      r_frm_err  <= 1'b0;
      r_par_bit  <= 1'b0;
      r_stop0    <= 1'b0;
      data_out   <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      break_det  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      r_sync1  <= rx;
      r_rxs    <= r_sync1;
      rx_valid <= 1'b0;

      // The tick counter and sample latches run on every tick; IDLE
      // restarts the counter so bit timing is anchored to the start edge.
      if (baud_tick) begin
        r_tcnt <= r_tcnt + 1'b1;
        if (r_tcnt == C_T_S0) r_s0 <= r_rxs;
        if (r_tcnt == C_T_S1) r_s1 <= r_rxs;
      end

      case (r_state)
        S_IDLE: begin
          if (!r_rxs) begin
            r_state   <= S_START;
            r_tcnt    <= '0;
            r_par_err <= 1'b0;
            r_frm_err <= 1'b0;
            busy      <= 1'b1;
          end
        end

        S_START: begin
          if (w_at_vote && w_vote) begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
          end else if (w_bit_end) begin
            r_state <= S_DATA;
            r_bcnt  <= '0;
          end
        end

        S_DATA: begin
          if (w_at_vote) r_shift <= {w_vote, r_shift[DATA_BITS-1:1]};
          if (w_bit_end) begin
            if (r_bcnt == C_B_LAST_DATA) begin
              r_state <= (PARITY != 0) ? S_PARITY : S_STOP;
              r_bcnt  <= '0;
            end else begin
              r_bcnt <= r_bcnt + 1'b1;
            end
          end
        end

        S_PARITY: begin
          if (w_at_vote) begin
            r_par_bit <= w_vote;
            r_par_err <= w_par_mis;
          end
          if (w_bit_end) begin
            r_state <= S_STOP;
            r_bcnt  <= '0;
          end
        end

        S_STOP: begin
          if (w_at_vote) begin
            if (r_bcnt == '0) r_stop0 <= w_vote;
            if (!w_vote) r_frm_err <= 1'b1;
            // Leave mid last stop bit so a back-to-back start edge is seen.
            if (r_bcnt == C_B_LAST_STOP) begin
              data_out   <= r_shift;
              parity_err <= r_par_err;
              frame_err  <= w_frm_now;
              break_det  <= w_brk;
              rx_valid   <= 1'b1;
              r_state    <= w_frm_now ? S_WAIT_HIGH : S_IDLE;
              busy       <= w_frm_now;
            end
          end else if (w_bit_end) begin
            r_bcnt <= r_bcnt + 1'b1;
          end
        end

        S_WAIT_HIGH: begin
          // A line held low yields one frame only; wait for it to recover.
          if (r_rxs) begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
          end
        end

        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_cfg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx_cfg
//  Purpose  : Self-checking bench for uart_rx_cfg. Three instances cover
//             8N1/OS16, 8E1/OS16 and 7O2/OS8. A frame-level model predicts
//             each frame's word, flags and completion tick; a monitor checks
//             every rx_valid against a scoreboard queue.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_cfg;

  typedef struct {
    int         inst;
    logic [8:0] data;
    logic       pe;
    logic       fe;
    logic       bd;
    int         tick;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       baud_tick;
  logic [2:0] rx_l;
  logic [2:0] vld, pe, fe, bd, bsy;
  logic [7:0] d_a, d_b;
  logic [6:0] d_c;
  logic [8:0] dout [3];

  int   n_checks = 0;
  int   n_pass   = 0;
  int   tick_cnt = 0;
  exp_t sb[$];
  logic [2:0] prev_vld = 3'b000;

  assign dout[0] = {1'b0, d_a};
  assign dout[1] = {1'b0, d_b};
  assign dout[2] = {2'b00, d_c};

  uart_rx_cfg #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .OVERSAMPLE(16)) u_a (
    .clk(clk), .rst(rst), .rx(rx_l[0]), .baud_tick(baud_tick),
    .data_out(d_a), .rx_valid(vld[0]), .parity_err(pe[0]),
    .frame_err(fe[0]), .break_det(bd[0]), .busy(bsy[0]));

  uart_rx_cfg #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .OVERSAMPLE(16)) u_b (
    .clk(clk), .rst(rst), .rx(rx_l[1]), .baud_tick(baud_tick),
    .data_out(d_b), .rx_valid(vld[1]), .parity_err(pe[1]),
    .frame_err(fe[1]), .break_det(bd[1]), .busy(bsy[1]));

  uart_rx_cfg #(.DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .OVERSAMPLE(8)) u_c (
    .clk(clk), .rst(rst), .rx(rx_l[2]), .baud_tick(baud_tick),
    .data_out(d_c), .rx_valid(vld[2]), .parity_err(pe[2]),
    .frame_err(fe[2]), .break_det(bd[2]), .busy(bsy[2]));

  always #5 clk = ~clk;

  // Ticks at least four clocks apart so the start edge is always detected
  // before the next tick, keeping the bench's tick count aligned to the DUT.
  initial begin
    baud_tick = 1'b0;
    forever begin
      repeat ($urandom_range(3, 5)) @(negedge clk);
      baud_tick = 1'b1;
      @(negedge clk);
      baud_tick = 1'b0;
    end
  end

  always @(posedge clk) if (baud_tick) tick_cnt <= tick_cnt + 1;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic int cfg_d(int i);  return (i == 2) ? 7 : 8;  endfunction
  function automatic int cfg_p(int i);  return (i == 0) ? 0 : ((i == 1) ? 2 : 1); endfunction
  function automatic int cfg_s(int i);  return (i == 2) ? 2 : 1;  endfunction
  function automatic int cfg_os(int i); return (i == 2) ? 8 : 16; endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
  endtask

  // Frame-level reference: status follows from the bits put on the line.
  function automatic exp_t model(int inst, logic [8:0] dm, logic par, logic [1:0] stops, int t0);
    exp_t e;
    int p    = cfg_p(inst);
    int s    = cfg_s(inst);
    int os   = cfg_os(inst);
    int ones = $countones(dm) + int'(par);
    e.inst = inst;
    e.data = dm;
    e.pe   = (p == 0) ? 1'b0 : ((p == 2) ? ((ones % 2) != 0) : ((ones % 2) != 1));
    e.fe   = (stops[0] == 1'b0) || (s == 2 && stops[1] == 1'b0);
    e.bd   = (dm == 0) && (p == 0 || par == 1'b0) && (stops[0] == 1'b0);
    e.tick = t0 + (1 + cfg_d(inst) + ((p != 0) ? 1 : 0) + s - 1) * os + os / 2 + 2;
    return e;
  endfunction

  // Returns at the falling edge after the next consumed baud tick.
  task automatic next_tick();
    do @(posedge clk); while (!baud_tick);
    @(negedge clk);
  endtask

  task automatic idle(input int inst, input int nbits);
    rx_l[inst] = 1'b1;
    repeat (nbits * cfg_os(inst)) next_tick();
  endtask

  task automatic send_frame(input int inst, input logic [8:0] data, input bit flip_par,
                            input logic [1:0] stops, input int noise_bit);
    int         d  = cfg_d(inst);
    int         p  = cfg_p(inst);
    int         os = cfg_os(inst);
    logic [8:0] dm;
    logic       par;
    logic       bits[$];
    logic       v;
    int         t0;
    dm  = data & 9'((1 << d) - 1);
    par = ((p == 2) ? (^dm) : ~(^dm)) ^ flip_par;
    bits.push_back(1'b0);
    for (int k = 0; k < d; k++) bits.push_back(dm[k]);
    if (p != 0) bits.push_back(par);
    for (int k = 0; k < cfg_s(inst); k++) bits.push_back(stops[k]);
    next_tick();
    t0 = tick_cnt;
    sb.push_back(model(inst, dm, par, stops, t0));
    for (int b = 0; b < bits.size(); b++) begin
      for (int j = 0; j < os; j++) begin
        v = bits[b];
        if (noise_bit >= 0 && b == noise_bit + 1 && j == os / 2) v = ~v;
        rx_l[inst] = v;
        next_tick();
      end
    end
  endtask

  task automatic chk_all_zero(input string tag);
    for (int i = 0; i < 3; i++) begin
      chk({tag, "_data"}, dout[i], 0);
      chk({tag, "_flags"}, {vld[i], pe[i], fe[i], bd[i], bsy[i]}, 0);
    end
  endtask

  // Monitor: every rx_valid pops one prediction.
  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      if (vld[i]) begin
        chk("valid_width", prev_vld[i], 0);
        if (sb.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_valid: actual=valid on inst %0d required=none", i);
        end else begin
          e = sb.pop_front();
          chk("inst", i, e.inst);
          chk("data", dout[i], e.data);
          chk("flags", {pe[i], fe[i], bd[i]}, {e.pe, e.fe, e.bd});
          chk("latency_tick", tick_cnt, e.tick);
        end
      end
    end
    prev_vld = vld;
  end

  initial begin
    logic [1:0] stops;
    int         inst;
    rst  = 1'b1;
    rx_l = 3'b111;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // 8N1 basic word
    send_frame(0, 9'h0A5, 0, 2'b11, -1);
    idle(0, 1);
    // 8E1 forced bad parity, then a good frame clears it
    send_frame(1, 9'h03C, 1, 2'b11, -1);
    idle(1, 1);
    send_frame(1, 9'h001, 0, 2'b11, -1);
    idle(1, 1);
    // 7O2 second stop low: stuck in WAIT_HIGH until the line rises
    send_frame(2, 9'h055, 0, 2'b01, -1);
    repeat (4) @(negedge clk);
    chk("wait_high_busy", bsy[2], 1);
    rx_l[2] = 1'b1;
    repeat (4) @(negedge clk);
    chk("wait_high_exit_busy", bsy[2], 0);
    idle(2, 1);

    // 3-tick low glitch while idle
    next_tick();
    rx_l[0] = 1'b0;
    repeat (3) next_tick();
    idle(0, 2);
    chk("glitch_busy", bsy[0], 0);

    // single inverted sample in data bit 3
    send_frame(0, 9'h0B6, 0, 2'b11, 3);
    idle(0, 1);

    // break: line low for 20 bit times yields exactly one frame
    next_tick();
    rx_l[0] = 1'b0;
    sb.push_back(model(0, 9'h000, 1'b0, 2'b00, tick_cnt));
    repeat (20 * 16) next_tick();
    chk("break_hold_busy", bsy[0], 1);
    idle(0, 2);
    chk("break_release_busy", bsy[0], 0);

    // reset mid-DATA, then a fresh frame
    next_tick();
    rx_l[0] = 1'b0;
    repeat (16) next_tick();
    for (int k = 0; k < 3; k++) begin
      rx_l[0] = k[0];
      repeat (16) next_tick();
    end
    rx_l[0] = 1'b1;
    repeat (8) next_tick();
    chk("mid_data_busy", bsy[0], 1);
    rst = 1'b1;
    #1;
    chk_all_zero("async_reset");
    rx_l = 3'b111;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    idle(0, 1);
    send_frame(0, 9'h0C3, 0, 2'b11, -1);
    idle(0, 1);

    // randomized frames on every configuration
    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < 3; i++) begin
        inst = i;
        stops[0] = ($urandom_range(0, 5) != 0);
        stops[1] = (cfg_s(inst) == 1) ? 1'b1 : ($urandom_range(0, 5) != 0);
        send_frame(inst, ($urandom_range(0, 7) == 0) ? 9'h000 : 9'($urandom),
                   ($urandom_range(0, 3) == 0),
                   stops,
                   ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, cfg_d(inst) - 1)) : -1);
        if (stops[cfg_s(inst) - 1] == 1'b0) idle(inst, int'($urandom_range(1, 2)));
        else idle(inst, int'($urandom_range(0, 2)));
      end
    end

    idle(0, 2);
    chk("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_rx_cfg.md
# uart_rx_cfg

Parametrised UART receiver: the next-generation serial input stage of the UART block. It oversamples `rx` using an external `baud_tick`, majority-votes each bit, and supports configurable data width, optional parity, one or two stop bits, and oversampling ratio. Each frame is delivered as a one-cycle `rx_valid` pulse with parity, framing and break status. It sits between the pad-side `rx` line and the host-side receive FIFO or register interface.

## Interface
- `DATA_BITS`, 8, data bits per frame, legal 5..9
- `PARITY`, 0, 0 = none, 1 = odd, 2 = even
- `STOP_BITS`, 1, 1 or 2
- `OVERSAMPLE`, 16, `baud_tick` pulses per bit; power of two, ≥ 8
- `clk`  in  1  system clock
- `rst`  in  1  asynchronous, active-high reset
- `rx`  in  1  serial line, idle high, asynchronous to `clk`
- `baud_tick`  in  1  one-`clk` pulse at `OVERSAMPLE` × baud rate
- `data_out`  out  `DATA_BITS`  last received word, LSB = first bit on the line
- `rx_valid`  out  1  one-cycle pulse, frame complete
- `parity_err`  out  1  parity mismatch on last frame
- `frame_err`  out  1  a stop bit sampled low on last frame
- `break_det`  out  1  last frame was a break condition
- `busy`  out  1  high in every state except IDLE

## Operation
- `rx` passes through a 2-flop synchroniser (both flops reset to 1). All logic below uses the synchronised value `rxs`.
- Tick counter `tcnt`, width log2(`OVERSAMPLE`), advances only on `baud_tick`. Bit counter counts up to `DATA_BITS`−1.
- Sample points are at `tcnt` = OS/2−1, OS/2 and OS/2+1, where OS = `OVERSAMPLE`. The bit value is the majority of the three samples and is decided on the tick at OS/2+1.
- **IDLE:** `rxs` = 0 → enter START, clear `tcnt`.
- **START:** at the vote, if the vote = 1, the start was false: go to IDLE with no output.
  - On the tick where `tcnt` = OS−1, go to DATA and clear the bit counter.
- **DATA:** the vote is shifted in LSB-first.
  - At `tcnt` = OS−1 of bit `DATA_BITS`−1, go to PARITY (if `PARITY` ≠ 0) or STOP.
- **PARITY:** the vote is compared with the XOR of the data bits.
  - Even: XOR(data) ^ bit must be 0. Odd: it must be 1.
  - A mismatch sets `parity_err` for this frame.
- **STOP:** each stop-bit vote must be 1, otherwise `frame_err` is set for this frame.
  - At the vote of the last stop bit: load `data_out`, `parity_err`, `frame_err` and `break_det`, and pulse `rx_valid`.
  - Then go to IDLE if no framing error, else go to WAIT_HIGH. This early exit (mid last stop bit) allows resync to a back-to-back start edge.
- **WAIT_HIGH:** stay until `rxs` = 1, then go to IDLE. A held-low line produces exactly one frame.
- A break is an all-zero frame: data = 0, parity vote = 0 when present, first stop vote = 0. A break sets `break_det` = 1 and `frame_err` = 1.
- Error flags and `data_out` hold their values until the next `rx_valid`. An erroneous frame still updates `data_out`.

## Timing
- Reset (asynchronous, any state): state = IDLE, counters = 0.
  - Outputs: `data_out` = 0, `rx_valid` = 0, all error flags = 0, `busy` = 0. Synchroniser flops = 1.
- Input latency: 2 `clk` from `rx` to `rxs`. IDLE → START one `clk` after `rxs` falls.
- `rx_valid` rises 1 `clk` after the `baud_tick` that takes the last stop-bit sample at OS/2+1, and lasts exactly 1 `clk`.
  - Flags and `data_out` change in the same cycle.
- In ticks after the start-edge detection, `rx_valid` occurs after (1 + `DATA_BITS` + P + `STOP_BITS` − 1) × OS + OS/2 + 2 ticks, where P = 1 if `PARITY` ≠ 0.
- `baud_tick` held low freezes the FSM and counters. `baud_tick` high continuously is legal; it simply runs the FSM faster.
- `busy` rises with entry to START and falls on entry to IDLE.

## Test plan
- 8N1, OS = 16, send 0xA5 → one `rx_valid`, `data_out` = 0xA5, `parity_err` = `frame_err` = `break_det` = 0.
- 8E1, send 0x3C with parity bit forced to 1 → `data_out` = 0x3C, `parity_err` = 1. The next good frame 0x01 clears it.
- 7O2, send 0x55 with the second stop bit low → `frame_err` = 1, FSM in WAIT_HIGH. Raising `rx` returns to IDLE, `busy` = 0.
- Noise cases:
  - 3-tick low glitch while idle → no `rx_valid`, back to IDLE.
  - Single-tick inverted sample at OS/2 of data bit 3 → correct word received.
- Break: hold `rx` low for 20 bit times (8N1) → exactly one `rx_valid` with `data_out` = 0x00, `frame_err` = `break_det` = 1. Nothing further until `rx` returns high.
- Assert `rst` mid-DATA → all outputs 0 immediately. After release, a fresh frame 0xC3 is received correctly.
